// File: rtl/cc_screen_sequencer.sv
// cc_screen_sequencer
//   Frame source for the Frogger LED matrix. Loads a glyph or a tiled
//   obstacle map into a registered frame buffer whenever the game state or
//   level changes. Scrolls obstacle lanes on each tick. Flags frog/obstacle
//   overlap, and pulses an active-low load strobe on every frame change.
//
//   Optional feature: define CC_SCREENSEQUENCER_BLINK_EN to make the
//   win/lose screens (states 010/011) blink every BLINK_TICKS ticks.
//
// Ports
//   CC_SCREENSEQUENCER_CLOCK_50             system clock
//   CC_SCREENSEQUENCER_RESET_InLow          async active-low reset
//   CC_SCREENSEQUENCER_tick_InHigh          one-cycle animation tick
//   CC_SCREENSEQUENCER_state_data_InBus     game state code
//   CC_SCREENSEQUENCER_level_data_InBus     level code (1..4)
//   CC_SCREENSEQUENCER_positionX_data_InBus frog column
//   CC_SCREENSEQUENCER_positionY_data_InBus frog row (0 = bottom)
//   CC_SCREENSEQUENCER_frame_data_OutBus    row r at [r*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH]
//   CC_SCREENSEQUENCER_load_OutLow          low one cycle per frame change
//   CC_SCREENSEQUENCER_collision_OutHigh    frog cell on a lit obstacle

// One scrolling lane: odd rows rotate toward the MSB, even rows toward the LSB.
module cc_screen_sequencer_row_rot #(
  parameter int W = 8
) (
  input  logic [W-1:0] row,
  input  logic         odd,
  output logic [W-1:0] rot
);
  assign rot = odd ? {row[W-2:0], row[W-1]} : {row[0], row[W-1:1]};
endmodule

module cc_screen_sequencer #(
  parameter int NUMBER_DATAWIDTH        = 8,
  parameter int NUMBER_ROWS             = 8,
  parameter int DATAWIDTH_STATE         = 3,
  parameter int DATAWIDTH_LEVEL         = 3,
  parameter int FROGGPOSITION_DATAWIDTH = 3,
  parameter int BLINK_TICKS             = 4
) (
  input  logic                                    CC_SCREENSEQUENCER_CLOCK_50,
  input  logic                                    CC_SCREENSEQUENCER_RESET_InLow,
  input  logic                                    CC_SCREENSEQUENCER_tick_InHigh,
  input  logic [DATAWIDTH_STATE-1:0]              CC_SCREENSEQUENCER_state_data_InBus,
  input  logic [DATAWIDTH_LEVEL-1:0]              CC_SCREENSEQUENCER_level_data_InBus,
  input  logic [FROGGPOSITION_DATAWIDTH-1:0]      CC_SCREENSEQUENCER_positionX_data_InBus,
  input  logic [FROGGPOSITION_DATAWIDTH-1:0]      CC_SCREENSEQUENCER_positionY_data_InBus,
  output logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] CC_SCREENSEQUENCER_frame_data_OutBus,
  output logic                                    CC_SCREENSEQUENCER_load_OutLow,
  output logic                                    CC_SCREENSEQUENCER_collision_OutHigh
);
  localparam int NR  = NUMBER_ROWS;
  localparam int NC  = NUMBER_DATAWIDTH;
  localparam int DS  = DATAWIDTH_STATE;
  localparam int DL  = DATAWIDTH_LEVEL;
  localparam int FPW = FROGGPOSITION_DATAWIDTH;

  // 8x8 tables, row 7 in the top byte, column c is bit c of each byte.
  localparam logic [63:0] G_FACE   = 64'h247EFFDB7E42BD81;
  localparam logic [63:0] G_TROPHY = 64'h3CFFBD7E3C18183C;
  localparam logic [63:0] G_SKULL  = 64'h7EFFBD99FF66663C;
  localparam logic [63:0] G_CHECK  = 64'h000103068CD87020;
  localparam logic [63:0] G_NUM1   = 64'h183878181818183C;
  localparam logic [63:0] G_NUM2   = 64'h3C6602060C18327E;
  localparam logic [63:0] G_NUM3   = 64'h3C66060C0606663C;
  localparam logic [63:0] G_NUM4   = 64'h0C0C7E7E4464341C;
  localparam logic [63:0] M_LVL1   = 64'hEF00C00300600000;
  localparam logic [63:0] M_LVL2   = 64'hFB30380007001800;
  localparam logic [63:0] M_LVL3   = 64'hFB00F100F3E3C700;
  localparam logic [63:0] M_LVL4   = 64'hDF1CE007000CC700;

  typedef enum logic [1:0] {S_IDLE, S_STATIC, S_SCROLL, S_BLINK} fsm_t;
  typedef logic [NR-1:0][NC-1:0] frame_t;

  wire gclk   = CC_SCREENSEQUENCER_CLOCK_50;
  wire grst_n = CC_SCREENSEQUENCER_RESET_InLow;
  wire tick   = CC_SCREENSEQUENCER_tick_InHigh;
  wire [DS-1:0]  st_in = CC_SCREENSEQUENCER_state_data_InBus;
  wire [DL-1:0]  lv_in = CC_SCREENSEQUENCER_level_data_InBus;
  wire [FPW-1:0] pos_x = CC_SCREENSEQUENCER_positionX_data_InBus;
  wire [FPW-1:0] pos_y = CC_SCREENSEQUENCER_positionY_data_InBus;

  // Glyphs sit in the bottom-left 8x8 corner; obstacle maps tile the matrix.
  function automatic frame_t build_frame(input logic [DS-1:0] st, input logic [DL-1:0] lv);
    logic [63:0] g;
    logic        tile;
    frame_t      f;
    g    = '0;
    tile = 1'b0;
    f    = '0;
    case (st)
      DS'(1): g = G_FACE;
      DS'(2): g = G_TROPHY;
      DS'(3): g = G_SKULL;
      DS'(5): g = G_CHECK;
      DS'(6): case (lv)
                DL'(1):  g = G_NUM1;
                DL'(2):  g = G_NUM2;
                DL'(3):  g = G_NUM3;
                DL'(4):  g = G_NUM4;
                default: g = '0;
              endcase
      DS'(4): begin
                tile = 1'b1;
                case (lv)
                  DL'(1):  g = M_LVL1;
                  DL'(2):  g = M_LVL2;
                  DL'(3):  g = M_LVL3;
                  DL'(4):  g = M_LVL4;
                  default: g = '0;
                endcase
              end
      default: g = '0;
    endcase
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (tile)
          f[r][c] = g[6'(((r % 8) * 8) + (c % 8))];
        else if (r < 8 && c < 8)
          f[r][c] = g[6'((r * 8) + c)];
    return f;
  endfunction

  function automatic fsm_t fsm_for(input logic [DS-1:0] st);
    case (st)
      DS'(1), DS'(5), DS'(6): fsm_for = S_STATIC;
      DS'(4):                 fsm_for = S_SCROLL;
`ifdef CC_SCREENSEQUENCER_BLINK_EN
      DS'(2), DS'(3):         fsm_for = S_BLINK;
`else
      DS'(2), DS'(3):         fsm_for = S_STATIC;
`endif
      default:                fsm_for = S_IDLE;
    endcase
  endfunction

  logic [DS-1:0] state_q;
  logic [DL-1:0] level_q;
  fsm_t          fsm_q;
  frame_t        frame_q;
  frame_t        rot_frame;
  logic          load_n_q;
  logic          coll_q;
  logic          coll_hit;
  logic          changed;

  assign changed = (st_in != state_q) || (lv_in != level_q);

  // Top and bottom rows are safe zones and never scroll.
  assign rot_frame[0]    = frame_q[0];
  assign rot_frame[NR-1] = frame_q[NR-1];
  for (genvar r = 1; r < NR - 1; r++) begin : g_lane
    cc_screen_sequencer_row_rot #(.W(NC)) u_rot (
      .row (frame_q[r]),
      .odd (1'(r % 2)),
      .rot (rot_frame[r])
    );
  end

  // Position decode by match rather than indexing so out-of-range X/Y
  // simply never hits a cell.
  always_comb begin
    coll_hit = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pos_y == FPW'(r) && pos_x == FPW'(c))
          coll_hit = frame_q[r][c];
  end

`ifdef CC_SCREENSEQUENCER_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  frame_t        glyph_q;
  assign glyph_q = build_frame(state_q, level_q);
`endif

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q  <= '0;
      level_q  <= '0;
      fsm_q    <= S_IDLE;
      frame_q  <= '0;
      load_n_q <= 1'b1;
      coll_q   <= 1'b0;
`ifdef CC_SCREENSEQUENCER_BLINK_EN
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
`endif
    end else begin
      coll_q   <= (state_q == DS'(4)) && coll_hit;
      load_n_q <= 1'b1;
      if (changed) begin
        // A change takes priority; a coincident tick is dropped.
        state_q  <= st_in;
        level_q  <= lv_in;
        frame_q  <= build_frame(st_in, lv_in);
        fsm_q    <= fsm_for(st_in);
        load_n_q <= 1'b0;
`ifdef CC_SCREENSEQUENCER_BLINK_EN
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
`endif
      end else if (tick) begin
        case (fsm_q)
          S_SCROLL: begin
            frame_q  <= rot_frame;
            load_n_q <= 1'b0;
          end
`ifdef CC_SCREENSEQUENCER_BLINK_EN
          S_BLINK: begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
              blink_cnt <= '0;
              blink_ph  <= ~blink_ph;
              // Leaving phase 1 restores the glyph; entering it blanks.
              frame_q   <= blink_ph ? glyph_q : '0;
              load_n_q  <= 1'b0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign CC_SCREENSEQUENCER_frame_data_OutBus = frame_q;
  assign CC_SCREENSEQUENCER_load_OutLow       = load_n_q;
  assign CC_SCREENSEQUENCER_collision_OutHigh = coll_q;

endmodule

// File: tb/tb_cc_screen_sequencer.sv
// Bench for cc_screen_sequencer: an 8x8 and a 16x16 instance share stimulus.
// A row-array model predicts frame/load/collision for both every cycle;
// directed literals pin the model against the glyph/map tables.
module tb_cc_screen_sequencer;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  st = '0;
  logic [2:0]  lv = '0;
  logic [3:0]  px = '0;
  logic [3:0]  py = '0;
  logic [63:0]  f8;
  logic [255:0] f16;
  logic ld8, ld16, co8, co16;

  always #5 clk = ~clk;

  cc_screen_sequencer #(.NUMBER_DATAWIDTH(8), .NUMBER_ROWS(8), .DATAWIDTH_STATE(3),
    .DATAWIDTH_LEVEL(3), .FROGGPOSITION_DATAWIDTH(4), .BLINK_TICKS(BT)) dut8 (
    .CC_SCREENSEQUENCER_CLOCK_50(clk), .CC_SCREENSEQUENCER_RESET_InLow(rst_n),
    .CC_SCREENSEQUENCER_tick_InHigh(tick), .CC_SCREENSEQUENCER_state_data_InBus(st),
    .CC_SCREENSEQUENCER_level_data_InBus(lv), .CC_SCREENSEQUENCER_positionX_data_InBus(px),
    .CC_SCREENSEQUENCER_positionY_data_InBus(py), .CC_SCREENSEQUENCER_frame_data_OutBus(f8),
    .CC_SCREENSEQUENCER_load_OutLow(ld8), .CC_SCREENSEQUENCER_collision_OutHigh(co8));

  cc_screen_sequencer #(.NUMBER_DATAWIDTH(16), .NUMBER_ROWS(16), .DATAWIDTH_STATE(3),
    .DATAWIDTH_LEVEL(3), .FROGGPOSITION_DATAWIDTH(4), .BLINK_TICKS(BT)) dut16 (
    .CC_SCREENSEQUENCER_CLOCK_50(clk), .CC_SCREENSEQUENCER_RESET_InLow(rst_n),
    .CC_SCREENSEQUENCER_tick_InHigh(tick), .CC_SCREENSEQUENCER_state_data_InBus(st),
    .CC_SCREENSEQUENCER_level_data_InBus(lv), .CC_SCREENSEQUENCER_positionX_data_InBus(px),
    .CC_SCREENSEQUENCER_positionY_data_InBus(py), .CC_SCREENSEQUENCER_frame_data_OutBus(f16),
    .CC_SCREENSEQUENCER_load_OutLow(ld16), .CC_SCREENSEQUENCER_collision_OutHigh(co16));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int pulses8 = 0;
  int pulses16 = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] faces [4] = '{64'h247EFFDB7E42BD81, 64'h3CFFBD7E3C18183C,
                             64'h7EFFBD99FF66663C, 64'h000103068CD87020};
  logic [63:0] nums  [4] = '{64'h183878181818183C, 64'h3C6602060C18327E,
                             64'h3C66060C0606663C, 64'h0C0C7E7E4464341C};
  logic [63:0] maps  [4] = '{64'hEF00C00300600000, 64'hFB30380007001800,
                             64'hFB00F100F3E3C700, 64'hDF1CE007000CC700};

  logic [15:0] mrow [2][16];
  logic [2:0]  mst [2];
  logic [2:0]  mlv [2];
  bit          mph [2];
  int          mcnt [2];
  logic        mload [2];
  logic        mcoll [2];

  function automatic logic [63:0] tbl(input logic [2:0] s, input logic [2:0] l);
    bit lok;
    lok = (l >= 3'd1 && l <= 3'd4);
    case (s)
      3'd1: return faces[0];
      3'd2: return faces[1];
      3'd3: return faces[2];
      3'd5: return faces[3];
      3'd6: return lok ? nums[l - 3'd1] : 64'h0;
      3'd4: return lok ? maps[l - 3'd1] : 64'h0;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [15:0] row_of(input logic [2:0] s, input logic [2:0] l,
                                         input int r, input int nc);
    logic [63:0] g;
    logic [7:0]  b;
    logic [15:0] v;
    g = tbl(s, l);
    v = '0;
    if (s == 3'd4) begin
      b = g[(r % 8) * 8 +: 8];
      for (int c = 0; c < nc; c++) v[c] = b[c % 8];
    end else if (r < 8) begin
      v[7:0] = g[r * 8 +: 8];
    end
    return v;
  endfunction

  function automatic logic [255:0] flat(input int i, input int nr, input int nc);
    logic [255:0] f;
    f = '0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        f[r * nc + c] = mrow[i][r][c];
    return f;
  endfunction

  task automatic m_reset(input int i);
    for (int r = 0; r < 16; r++) mrow[i][r] = '0;
    mst[i] = '0; mlv[i] = '0; mph[i] = 0; mcnt[i] = 0;
    mload[i] = 1'b1; mcoll[i] = 1'b0;
  endtask

  task automatic m_step(input int i, input int nr, input int nc);
    logic [15:0] mask, v;
    mask = (nc == 16) ? 16'hFFFF : 16'h00FF;
    mcoll[i] = (mst[i] == 3'd4) && (int'(py) < nr) && (int'(px) < nc) && mrow[i][py][px];
    mload[i] = 1'b1;
    if (st !== mst[i] || lv !== mlv[i]) begin
      mst[i] = st; mlv[i] = lv; mph[i] = 0; mcnt[i] = 0; mload[i] = 1'b0;
      for (int r = 0; r < 16; r++) mrow[i][r] = (r < nr) ? row_of(st, lv, r, nc) : 16'h0;
    end else if (tick && mst[i] == 3'd4) begin
      for (int r = 1; r < nr - 1; r++) begin
        v = mrow[i][r];
        if (r % 2) v = (v << 1) | (v >> (nc - 1));
        else       v = (v >> 1) | (v << (nc - 1));
        mrow[i][r] = v & mask;
      end
      mload[i] = 1'b0;
    end
`ifdef CC_SCREENSEQUENCER_BLINK_EN
    else if (tick && (mst[i] == 3'd2 || mst[i] == 3'd3)) begin
      mcnt[i]++;
      if (mcnt[i] == BT) begin
        mcnt[i] = 0;
        mph[i] = ~mph[i];
        for (int r = 0; r < 16; r++)
          mrow[i][r] = (r < nr && !mph[i]) ? row_of(mst[i], mlv[i], r, nc) : 16'h0;
        mload[i] = 1'b0;
      end
    end
`endif
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++)
        if (!rst_n) m_reset(i);
        else        m_step(i, (i == 1) ? 16 : 8, (i == 1) ? 16 : 8);
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame8",  {192'b0, f8}, flat(0, 8, 8));
      chk("load8",   {255'b0, ld8}, {255'b0, mload[0]});
      chk("coll8",   {255'b0, co8}, {255'b0, mcoll[0]});
      chk("frame16", f16, flat(1, 16, 16));
      chk("load16",  {255'b0, ld16}, {255'b0, mload[1]});
      chk("coll16",  {255'b0, co16}, {255'b0, mcoll[1]});
    end
  end

  always @(negedge clk) begin
    if (chk_en && !ld8)  pulses8  <= pulses8 + 1;
    if (chk_en && !ld16) pulses16 <= pulses16 + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_tick;
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int p0;
  initial begin
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("rst_frame8", {192'b0, f8}, 256'h0);
    chk("rst_load8", {255'b0, ld8}, 256'h1);
    chk("rst_coll8", {255'b0, co8}, 256'h0);
    rst_n = 1'b1;
    cyc(2);

    // face glyph
    p0 = pulses8;
    st = 3'd1; cyc(1);
    chk("face_row7", {248'b0, f8[63:56]}, 256'h24);
    chk("face_row0", {248'b0, f8[7:0]}, 256'h81);
    chk("face_load", {255'b0, ld8}, 256'h0);
    cyc(3);
    chk("face_pulses", 256'(pulses8 - p0), 256'd1);

    // level 1 obstacles, one scroll tick
    p0 = pulses8;
    st = 3'd4; lv = 3'd1; cyc(2);
    pulse_tick();
    chk("scr_row7", {248'b0, f8[63:56]}, 256'hEF);
    chk("scr_row5", {248'b0, f8[47:40]}, 256'h81);
    chk("scr_row4", {248'b0, f8[39:32]}, 256'h81);
    chk("scr_row2", {248'b0, f8[23:16]}, 256'h30);
    chk("scr16_row15", {240'b0, f16[255:240]}, 256'hEFEF);
    cyc(2);
    chk("scr_pulses", 256'(pulses8 - p0), 256'd2);

    // collision
    px = 4'd7; py = 4'd7; cyc(1);
    chk("coll_hit", {255'b0, co8}, 256'h1);
    px = 4'd4; cyc(1);
    chk("coll_miss", {255'b0, co8}, 256'h0);
    px = 4'd9; cyc(1);
    chk("coll_oob8", {255'b0, co8}, 256'h0);
    chk("coll_x9_16", {255'b0, co16}, 256'h1);
    px = 4'd7; st = 3'd5; cyc(2);
    chk("coll_after_101", {255'b0, co8}, 256'h0);

    // same-edge change and tick
    st = 3'd4; lv = 3'd2; cyc(3);
    p0 = pulses8;
    st = 3'd6; tick = 1'b1; cyc(1); tick = 1'b0;
    chk("num2_frame", {192'b0, f8}, {192'b0, 64'h3C6602060C18327E});
    pulse_tick();
    cyc(2);
    chk("num2_pulses", 256'(pulses8 - p0), 256'd1);

    // trophy with four ticks
    st = 3'd2; cyc(2);
    p0 = pulses8;
    for (int k = 1; k <= 4; k++) begin
      pulse_tick();
`ifdef CC_SCREENSEQUENCER_BLINK_EN
      if (k == 2) chk("blink_off", {192'b0, f8}, 256'h0);
`else
      if (k == 2) chk("blink_off", {192'b0, f8}, {192'b0, 64'h3CFFBD7E3C18183C});
`endif
      if (k == 4) chk("blink_on", {192'b0, f8}, {192'b0, 64'h3CFFBD7E3C18183C});
      cyc(1);
    end
`ifdef CC_SCREENSEQUENCER_BLINK_EN
    chk("blink_pulses", 256'(pulses8 - p0), 256'd2);
`else
    chk("blink_pulses", 256'(pulses8 - p0), 256'd0);
`endif

    // codes that produce a blank frame
    st = 3'd4; lv = 3'd0; cyc(2);
    chk("blank_lvl0", {192'b0, f8}, 256'h0);
    st = 3'd7; lv = 3'd3; cyc(2);
    chk("blank_111", {192'b0, f8}, 256'h0);
    st = 3'd6; lv = 3'd5; cyc(2);
    chk("blank_lvl5", {192'b0, f8}, 256'h0);

    // scrolling sweep of positions, model-checked
    st = 3'd4; lv = 3'd3; cyc(1);
    for (int i = 0; i < 24; i++) begin
      px = 4'(i % 16); py = 4'((i * 3) % 16);
      tick = (i % 3 == 0);
      cyc(1);
    end
    tick = 1'b0;

    // 16x16 level 4, reset mid-scroll
    st = 3'd4; lv = 3'd4; cyc(1);
    chk("m16_row15", {240'b0, f16[255:240]}, 256'hDFDF);
    chk("m16_row0", {240'b0, f16[15:0]}, 256'h0);
    pulse_tick();
    pulse_tick();
    rst_n = 1'b0; #1;
    chk("midrst_f16", f16, 256'h0);
    chk("midrst_f8", {192'b0, f8}, 256'h0);
    chk("midrst_ld16", {255'b0, ld16}, 256'h1);
    cyc(2);
    rst_n = 1'b1; cyc(1);
    chk("reload_row15", {240'b0, f16[255:240]}, 256'hDFDF);
    chk("reload_ld16", {255'b0, ld16}, 256'h0);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
